// File: rtl/jogo_pkg.sv
// Shared encodings for the ultimate tic-tac-toe sequencer: FSM states, cell symbols
// and the player-to-symbol mapping.
package jogo_pkg;

  typedef enum logic [3:0] {
    INICIAL  = 4'd0,
    PREPARA  = 4'd1,
    ESPERA   = 4'd2,
    LE       = 4'd3,
    VALIDA   = 4'd4,
    ESCREVE  = 4'd5,
    VERIFICA = 4'd6,
    FIM      = 4'd7
  } estado_t;

  localparam logic [1:0] VAZIO  = 2'b00;
  localparam logic [1:0] X      = 2'b01;
  localparam logic [1:0] O      = 2'b10;
  localparam logic [1:0] EMPATE = 2'b11;

  // Highest legal index for both macro board and cell selectors.
  localparam logic [3:0] ULTIMO_INDICE = 4'd8;

  function automatic logic [1:0] symbol(input logic jogador);
    return jogador ? O : X;
  endfunction

endpackage

// File: rtl/contador_timeout.sv
// Per-move cycle counter: cleared outside the wait state, counts while enabled and
// flags the last allowed cycle. Only instantiated when TIMEOUT_JOGADA_EN is defined.
module contador_timeout #(
  parameter int TIMEOUT_CICLOS = 50_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int LARGURA = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
  localparam logic [LARGURA-1:0] ULTIMO = LARGURA'(TIMEOUT_CICLOS - 1);

  logic [LARGURA-1:0] contagem_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      contagem_reg <= '0;
    end else if (clear) begin
      contagem_reg <= '0;
    end else if (enable && !terminal) begin
      contagem_reg <= contagem_reg + 1'b1;
    end
  end

  assign terminal = enable && (contagem_reg == ULTIMO);

endmodule

// File: rtl/sequenciador_partida.sv
// Turn sequencer for ultimate tic-tac-toe: request, validate, write and check each move.
// Optional per-move timeout is enabled by defining TIMEOUT_JOGADA_EN.
module sequenciador_partida
  import jogo_pkg::*;
#(
  parameter logic PRIMEIRO_JOGADOR = 1'b0,
  parameter int   TIMEOUT_CICLOS   = 50_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada_feita,
  input  logic [3:0] macro_sel,
  input  logic [3:0] micro_sel,
  input  logic [1:0] mem_rd_dado,
  input  logic       macro_fechado,
  input  logic       verifica_pronto,
  input  logic       jogo_venceu,
  input  logic       empate,
  input  logic       destino_fechado,
  output logic       iniciar_jogada,
  output logic       mem_ler,
  output logic       mem_escrever,
  output logic [1:0] mem_dado,
  output logic       inicia_verifica,
  output logic       jogador,
  output logic [3:0] macro_forcado,
  output logic       macro_livre,
  output logic       jogada_invalida,
  output logic       timeout_jogada,
  output logic       fim_jogo,
  output logic [1:0] vencedor,
  output logic [3:0] db_estado
);

  estado_t    estado_reg, estado_next;
  logic       jogador_reg, jogador_next;
  logic [3:0] macro_forcado_reg, macro_forcado_next;
  logic       macro_livre_reg, macro_livre_next;
  logic [1:0] vencedor_reg, vencedor_next;
  logic [3:0] macro_reg, macro_next;
  logic [3:0] micro_reg, micro_next;
  logic       verifica_ativa_reg, verifica_ativa_next;
  logic       fim_timeout;
  logic       jogada_legal;

`ifdef TIMEOUT_JOGADA_EN
  contador_timeout #(
    .TIMEOUT_CICLOS (TIMEOUT_CICLOS)
  ) u_contador_timeout (
    .clock    (clock),
    .reset    (reset),
    .clear    (estado_reg != ESPERA),
    .enable   (estado_reg == ESPERA),
    .terminal (fim_timeout)
  );
`else
  assign fim_timeout = 1'b0;
`endif

  // The selected move is latched when it is accepted so later stages see a stable copy.
  assign jogada_legal = (macro_reg <= ULTIMO_INDICE) &&
                        (micro_reg <= ULTIMO_INDICE) &&
                        (mem_rd_dado == VAZIO) &&
                        !macro_fechado &&
                        (macro_livre_reg || (macro_reg == macro_forcado_reg));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_reg         <= INICIAL;
      jogador_reg        <= PRIMEIRO_JOGADOR;
      macro_forcado_reg  <= 4'd0;
      macro_livre_reg    <= 1'b1;
      vencedor_reg       <= VAZIO;
      macro_reg          <= 4'd0;
      micro_reg          <= 4'd0;
      verifica_ativa_reg <= 1'b0;
    end else begin
      estado_reg         <= estado_next;
      jogador_reg        <= jogador_next;
      macro_forcado_reg  <= macro_forcado_next;
      macro_livre_reg    <= macro_livre_next;
      vencedor_reg       <= vencedor_next;
      macro_reg          <= macro_next;
      micro_reg          <= micro_next;
      verifica_ativa_reg <= verifica_ativa_next;
    end
  end

  always_comb begin
    estado_next         = estado_reg;
    jogador_next        = jogador_reg;
    macro_forcado_next  = macro_forcado_reg;
    macro_livre_next    = macro_livre_reg;
    vencedor_next       = vencedor_reg;
    macro_next          = macro_reg;
    micro_next          = micro_reg;
    verifica_ativa_next = 1'b0;
    iniciar_jogada      = 1'b0;
    mem_ler             = 1'b0;
    mem_escrever        = 1'b0;
    mem_dado            = VAZIO;
    inicia_verifica     = 1'b0;
    jogada_invalida     = 1'b0;
    timeout_jogada      = 1'b0;

    case (estado_reg)
      INICIAL: begin
        if (iniciar) begin
          jogador_next       = PRIMEIRO_JOGADOR;
          macro_forcado_next = 4'd0;
          macro_livre_next   = 1'b1;
          vencedor_next      = VAZIO;
          estado_next        = PREPARA;
        end
      end
      PREPARA: begin
        iniciar_jogada = 1'b1;
        estado_next    = ESPERA;
      end
      ESPERA: begin
        // A move arriving on the terminal cycle takes precedence over the timeout.
        if (jogada_feita) begin
          macro_next  = macro_sel;
          micro_next  = micro_sel;
          estado_next = LE;
        end else if (fim_timeout) begin
          timeout_jogada = 1'b1;
          jogador_next   = !jogador_reg;
          estado_next    = PREPARA;
        end
      end
      LE: begin
        mem_ler     = 1'b1;
        estado_next = VALIDA;
      end
      VALIDA: begin
        if (jogada_legal) begin
          estado_next = ESCREVE;
        end else begin
          jogada_invalida = 1'b1;
          estado_next     = PREPARA;
        end
      end
      ESCREVE: begin
        mem_escrever = 1'b1;
        mem_dado     = symbol(jogador_reg);
        estado_next  = VERIFICA;
      end
      VERIFICA: begin
        // First cycle launches the checker; its result is only taken afterwards.
        inicia_verifica     = !verifica_ativa_reg;
        verifica_ativa_next = 1'b1;
        if (verifica_ativa_reg && verifica_pronto) begin
          verifica_ativa_next = 1'b0;
          if (jogo_venceu) begin
            vencedor_next = symbol(jogador_reg);
            estado_next   = FIM;
          end else if (empate) begin
            vencedor_next = EMPATE;
            estado_next   = FIM;
          end else begin
            macro_forcado_next = micro_reg;
            macro_livre_next   = destino_fechado;
            jogador_next       = !jogador_reg;
            estado_next        = PREPARA;
          end
        end
      end
      FIM: begin
        if (iniciar) begin
          jogador_next       = PRIMEIRO_JOGADOR;
          macro_forcado_next = 4'd0;
          macro_livre_next   = 1'b1;
          vencedor_next      = VAZIO;
          estado_next        = INICIAL;
        end
      end
      default: begin
        estado_next = INICIAL;
      end
    endcase
  end

  assign jogador       = jogador_reg;
  assign macro_forcado = macro_forcado_reg;
  assign macro_livre   = macro_livre_reg;
  assign vencedor      = vencedor_reg;
  assign fim_jogo      = (estado_reg == FIM);
  assign db_estado     = estado_reg;

endmodule

// File: tb/tb_sequenciador_partida.sv
// Self-checking bench for sequenciador_partida: table of directed turns, hand-written
// end-of-game / reset sequences, and random games against a board-level model.
module tb_sequenciador_partida;
  import jogo_pkg::*;

  localparam int TO_CICLOS = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       iniciar = 1'b0;
  logic       jogada_feita = 1'b0;
  logic [3:0] macro_sel = 4'd0;
  logic [3:0] micro_sel = 4'd0;
  logic [1:0] mem_rd_dado = 2'b00;
  logic       macro_fechado = 1'b0;
  logic       verifica_pronto = 1'b0;
  logic       jogo_venceu = 1'b0;
  logic       empate = 1'b0;
  logic       destino_fechado = 1'b0;
  logic       iniciar_jogada, mem_ler, mem_escrever, inicia_verifica;
  logic       jogador, macro_livre, jogada_invalida, timeout_jogada, fim_jogo;
  logic [1:0] mem_dado, vencedor;
  logic [3:0] macro_forcado, db_estado;

  int testes = 0;
  int falhas = 0;

  // Reference model: the 81 cells plus whose turn it is and where the next move must go.
  logic [1:0] tabuleiro [81];
  logic       m_jogador;
  logic [3:0] m_forcado;
  logic       m_livre;

  sequenciador_partida #(
    .PRIMEIRO_JOGADOR (1'b0),
    .TIMEOUT_CICLOS   (TO_CICLOS)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .iniciar         (iniciar),
    .jogada_feita    (jogada_feita),
    .macro_sel       (macro_sel),
    .micro_sel       (micro_sel),
    .mem_rd_dado     (mem_rd_dado),
    .macro_fechado   (macro_fechado),
    .verifica_pronto (verifica_pronto),
    .jogo_venceu     (jogo_venceu),
    .empate          (empate),
    .destino_fechado (destino_fechado),
    .iniciar_jogada  (iniciar_jogada),
    .mem_ler         (mem_ler),
    .mem_escrever    (mem_escrever),
    .mem_dado        (mem_dado),
    .inicia_verifica (inicia_verifica),
    .jogador         (jogador),
    .macro_forcado   (macro_forcado),
    .macro_livre     (macro_livre),
    .jogada_invalida (jogada_invalida),
    .timeout_jogada  (timeout_jogada),
    .fim_jogo        (fim_jogo),
    .vencedor        (vencedor),
    .db_estado       (db_estado)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] m;
    logic [3:0] u;
    logic [1:0] rd;
    logic       fech;
    logic       dfech;
    logic       exp_inval;
    logic       exp_jog;
    logic [3:0] exp_forc;
    logic       exp_livre;
  } vetor_t;

  vetor_t tabela [9];

  task automatic verifica(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    testes++;
    if (atual !== esperado) begin
      falhas++;
      $display("FAIL %s: got %0h expected %0h", nome, atual, esperado);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic modelo_reinicia;
    for (int i = 0; i < 81; i++) tabuleiro[i] = 2'b00;
    m_jogador = 1'b0;
    m_forcado = 4'd0;
    m_livre   = 1'b1;
  endtask

  // Plays one turn starting in the cycle iniciar_jogada is expected; ends in PREPARA,
  // FIM, or (when parar is set) on the first VERIFICA cycle.
  task automatic turno(input logic [3:0] m, input logic [3:0] u, input logic [1:0] rd,
                       input logic fech, input logic dfech, input logic venc, input logic emp,
                       input int lat, input bit parar, output bit terminou, output logic inval);
    bit         legal;
    logic [1:0] simb;
    terminou = 1'b0;
    simb = m_jogador ? 2'b10 : 2'b01;
    verifica("iniciar_jogada", iniciar_jogada, 1);
    verifica("jogador_turno", jogador, m_jogador);
    tick;
    verifica("pulso_iniciar_unico", iniciar_jogada, 0);
    verifica("timeout_zero", timeout_jogada, 0);
    macro_sel = m; micro_sel = u; mem_rd_dado = rd; macro_fechado = fech;
    jogada_feita = 1'b1;
    iniciar = 1'b1;
    tick;
    jogada_feita = 1'b0;
    iniciar = 1'b0;
    verifica("mem_ler", mem_ler, 1);
    tick;
    legal = (m < 9) && (u < 9) && (rd == 2'b00) && !fech && (m_livre || (m == m_forcado));
    inval = jogada_invalida;
    verifica("jogada_invalida", jogada_invalida, !legal);
    verifica("sem_escrita_valida", mem_escrever, 0);
    tick;
    $display("[TB] turno jogador=%0d macro=%0d micro=%0d legal=%0d", m_jogador, m, u, legal);
    if (!legal) begin
      verifica("sem_escrita_invalida", mem_escrever, 0);
      return;
    end
    verifica("mem_escrever", mem_escrever, 1);
    verifica("mem_dado", mem_dado, simb);
    tabuleiro[m * 9 + u] = simb;
    tick;
    verifica("inicia_verifica", inicia_verifica, 1);
    if (parar) return;
    tick;
    verifica("verifica_pulso_unico", inicia_verifica, 0);
    repeat (lat) tick;
    verifica_pronto = 1'b1; jogo_venceu = venc; empate = emp; destino_fechado = dfech;
    tick;
    verifica_pronto = 1'b0; jogo_venceu = 1'b0; empate = 1'b0; destino_fechado = 1'b0;
    if (venc || emp) begin
      terminou = 1'b1;
      verifica("fim_jogo", fim_jogo, 1);
      verifica("vencedor", vencedor, venc ? simb : 2'b11);
    end else begin
      m_forcado = u;
      m_livre   = dfech;
      m_jogador = !m_jogador;
      verifica("jogador_apos", jogador, m_jogador);
      verifica("macro_forcado", macro_forcado, m_forcado);
      verifica("macro_livre", macro_livre, m_livre);
    end
  endtask

  // From FIM: outputs hold, iniciar goes to INICIAL, a second iniciar opens a new game.
  task automatic reinicia_de_fim;
    logic [1:0] venc_salvo;
    venc_salvo = vencedor;
    jogada_feita = 1'b1;
    tick;
    jogada_feita = 1'b0;
    verifica("fim_mantido", fim_jogo, 1);
    verifica("vencedor_mantido", vencedor, venc_salvo);
    iniciar = 1'b1;
    tick;
    verifica("estado_inicial", db_estado, INICIAL);
    verifica("fim_jogo_baixo", fim_jogo, 0);
    tick;
    iniciar = 1'b0;
    verifica("novo_jogo_vencedor", vencedor, 2'b00);
    verifica("novo_jogo_jogador", jogador, 0);
    verifica("novo_jogo_livre", macro_livre, 1);
    verifica("novo_jogo_forcado", macro_forcado, 0);
    modelo_reinicia();
  endtask

  initial begin
    bit         fim;
    logic       inval;
    logic [3:0] rm, ru;
    logic [1:0] rrd;

    tabela[0] = '{4'd4, 4'd4, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 4'd4, 1'b0};
    tabela[1] = '{4'd2, 4'd0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 4'd4, 1'b0};
    tabela[2] = '{4'd4, 4'd1, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 4'd4, 1'b0};
    tabela[3] = '{4'd4, 4'd2, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 4'd4, 1'b0};
    tabela[4] = '{4'd4, 4'd3, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 1'b1};
    tabela[5] = '{4'd7, 4'd5, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 1'b0};
    tabela[6] = '{4'd9, 4'd0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 4'd5, 1'b0};
    tabela[7] = '{4'd5, 4'd9, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 4'd5, 1'b0};
    tabela[8] = '{4'd5, 4'd8, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd8, 1'b0};

    modelo_reinicia();
    repeat (2) @(posedge clock);
    #1;
    verifica("reset_estado", db_estado, INICIAL);
    verifica("reset_jogador", jogador, 0);
    verifica("reset_livre", macro_livre, 1);
    verifica("reset_forcado", macro_forcado, 0);
    verifica("reset_vencedor", vencedor, 0);
    verifica("reset_fim", fim_jogo, 0);
    verifica("reset_pulsos", {iniciar_jogada, mem_ler, mem_escrever, inicia_verifica,
                              jogada_invalida, timeout_jogada, mem_dado}, 0);
    reset = 1'b0;
    jogada_feita = 1'b1;
    tick;
    jogada_feita = 1'b0;
    verifica("inicial_espera_iniciar", db_estado, INICIAL);
    iniciar = 1'b1;
    tick;
    iniciar = 1'b0;

    for (int i = 0; i < 9; i++) begin
      turno(tabela[i].m, tabela[i].u, tabela[i].rd, tabela[i].fech, tabela[i].dfech,
            1'b0, 1'b0, i % 3, 1'b0, fim, inval);
      verifica($sformatf("tab%0d_invalida", i), inval, tabela[i].exp_inval);
      verifica($sformatf("tab%0d_jogador", i), jogador, tabela[i].exp_jog);
      verifica($sformatf("tab%0d_forcado", i), macro_forcado, tabela[i].exp_forc);
      verifica($sformatf("tab%0d_livre", i), macro_livre, tabela[i].exp_livre);
    end

    // X wins, then empate, then win-over-empate priority.
    turno(4'd8, 4'd0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b0, fim, inval);
    verifica("vitoria_x", vencedor, 2'b01);
    reinicia_de_fim();
    turno(4'd0, 4'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, fim, inval);
    verifica("vencedor_empate", vencedor, 2'b11);
    reinicia_de_fim();
    turno(4'd1, 4'd1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 2, 1'b0, fim, inval);
    verifica("prioridade_vitoria", vencedor, 2'b01);
    reinicia_de_fim();

    for (int n = 0; n < 300; n++) begin
      rm = ($urandom_range(0, 19) == 0) ? 4'(9 + $urandom_range(0, 6)) : 4'($urandom_range(0, 8));
      if ($urandom_range(0, 2) != 0 && !m_livre) rm = m_forcado;
      ru = ($urandom_range(0, 19) == 0) ? 4'(9 + $urandom_range(0, 6)) : 4'($urandom_range(0, 8));
      rrd = (rm < 9 && ru < 9) ? tabuleiro[rm * 9 + ru] : 2'b00;
      if ($urandom_range(0, 9) == 0) rrd = 2'($urandom_range(0, 3));
      turno(rm, ru, rrd, $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 29) == 0, $urandom_range(0, 29) == 0,
            $urandom_range(0, 3), 1'b0, fim, inval);
      if (fim) reinicia_de_fim();
    end

    // Asynchronous reset in the middle of VERIFICA.
    reset = 1'b1;
    tick;
    reset = 1'b0;
    iniciar = 1'b1;
    tick;
    iniciar = 1'b0;
    modelo_reinicia();
    turno(4'd4, 4'd4, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, fim, inval);
    turno(4'd4, 4'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, fim, inval);
    #2;
    reset = 1'b1;
    #1;
    verifica("async_estado", db_estado, INICIAL);
    verifica("async_jogador", jogador, 0);
    verifica("async_livre", macro_livre, 1);
    verifica("async_forcado", macro_forcado, 0);
    verifica("async_pulso", inicia_verifica, 0);
    verifica("async_vencedor", vencedor, 0);
    tick;
    reset = 1'b0;

`ifdef TIMEOUT_JOGADA_EN
    iniciar = 1'b1;
    tick;
    iniciar = 1'b0;
    tick;
    for (int k = 1; k <= TO_CICLOS; k++) begin
      verifica($sformatf("timeout_ciclo%0d", k), timeout_jogada, k == TO_CICLOS);
      tick;
    end
    verifica("timeout_prepara", iniciar_jogada, 1);
    verifica("timeout_jogador", jogador, 1);
    verifica("timeout_livre", macro_livre, 1);
    verifica("timeout_forcado", macro_forcado, 0);
    tick;
    repeat (TO_CICLOS - 1) tick;
    macro_sel = 4'd4; micro_sel = 4'd4; mem_rd_dado = 2'b00; macro_fechado = 1'b0;
    jogada_feita = 1'b1;
    #1;
    verifica("terminal_jogada_vence", timeout_jogada, 0);
    tick;
    jogada_feita = 1'b0;
    verifica("terminal_le", mem_ler, 1);
    verifica("terminal_jogador", jogador, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", testes, falhas);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
